// File: rtl/fc_result_writer.sv
// fc_result_writer: result stage of the 8-core fully-connected data mover.
// Each accepted beat of eight signed results is requantized to 8 bits,
// packed into two 32-bit words and queued in a small FIFO. The FIFO is
// drained into the output BRAM one word per cycle (word0 at 2k, word1 at
// 2k+1). Status (idle/busy/done/overflow) goes to the control register block.
// Optional feature macro: RELU_EN (negative results quantize to zero).
// DWIDTH must be 32 so that four 8-bit codes fill one BRAM word.

module fc_result_writer #(
    parameter int CNT_BIT    = 31,
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 12,
    parameter int SHIFT      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    input  logic               i_valid,
    input  logic [DWIDTH-1:0]  i_result_0,
    input  logic [DWIDTH-1:0]  i_result_1,
    input  logic [DWIDTH-1:0]  i_result_2,
    input  logic [DWIDTH-1:0]  i_result_3,
    input  logic [DWIDTH-1:0]  i_result_4,
    input  logic [DWIDTH-1:0]  i_result_5,
    input  logic [DWIDTH-1:0]  i_result_6,
    input  logic [DWIDTH-1:0]  i_result_7,
    output logic               o_idle,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic [AWIDTH-1:0]  addr_o,
    output logic               ce_o,
    output logic               we_o,
    output logic [DWIDTH-1:0]  d_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic signed [DWIDTH-1:0] Q_MAX_C = DWIDTH'(127);
    localparam logic signed [DWIDTH-1:0] Q_MIN_C = ~Q_MAX_C;   // -128

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Requantize one result: arithmetic shift, then clamp to an 8-bit code.
    function automatic logic [7:0] quant8(input logic [DWIDTH-1:0] x);
        logic signed [DWIDTH-1:0] y;
        y = $signed(x) >>> SHIFT;
`ifdef RELU_EN
        if (x[DWIDTH-1]) begin
            return 8'h00;
        end else if (y > Q_MAX_C) begin
            return 8'h7F;
        end else begin
            return y[7:0];
        end
`else
        if (y > Q_MAX_C) begin
            return 8'h7F;
        end else if (y < Q_MIN_C) begin
            return 8'h80;
        end else begin
            return y[7:0];
        end
`endif
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [CNT_BIT-1:0]    num_cnt_r;
    logic [CNT_BIT-1:0]    beats_in_r;
    logic                  q_valid_r;
    logic [DWIDTH-1:0]     q_word0_r;
    logic [DWIDTH-1:0]     q_word1_r;
    logic [2*DWIDTH-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [OCC_W-1:0]      fifo_cnt_r;
    logic                  phase_r;      // 1: word1 of the head entry is next
    logic [AWIDTH-1:0]     wr_addr_r;    // running word counter, wraps
    logic                  idle_s;
    logic                  busy_s;
    logic                  done_s;

    logic                  start_s;
    logic                  beat_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  run_end_s;
    logic [2*DWIDTH-1:0]   head_s;

    assign start_s      = (state_r == S_IDLE) && i_run;
    assign beat_s       = (state_r == S_RUN) && i_valid && (beats_in_r < num_cnt_r);
    assign fifo_full_s  = (fifo_cnt_r == OCC_W'(FIFO_DEPTH));
    assign fifo_empty_s = (fifo_cnt_r == {OCC_W{1'b0}});
    // The word1 write is the pop; it is only ever scheduled on a non-empty FIFO.
    assign pop_s        = phase_r;
    // A full FIFO still accepts a push on the edge that pops it.
    assign push_s       = q_valid_r && (!fifo_full_s || pop_s);
    assign drop_s       = q_valid_r && fifo_full_s && !pop_s;
    assign run_end_s    = (beats_in_r == num_cnt_r) && !q_valid_r && fifo_empty_s && !phase_r;
    assign head_s       = fifo_mem_r[rd_ptr_r];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: run on start pulse, finish when everything has drained.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (i_run) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (run_end_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Status decode from the next state so the registered flags track state_r.
    always_comb begin
        idle_s = 1'b0;
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_next_s)
            S_IDLE:  idle_s = 1'b1;
            S_RUN:   busy_s = 1'b1;
            S_DONE:  done_s = 1'b1;
            default: idle_s = 1'b1;
        endcase
    end

    // Registered status outputs, including the sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_idle     <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_idle <= idle_s;
            o_busy <= busy_s;
            o_done <= done_s;
            if (start_s) begin
                o_overflow <= 1'b0;
            end else if (drop_s) begin
                o_overflow <= 1'b1;
            end else begin
                o_overflow <= o_overflow;
            end
        end
    end

    // Beat accounting: latch the run length, count accepted beats (dropped ones too).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_cnt_r  <= {CNT_BIT{1'b0}};
            beats_in_r <= {CNT_BIT{1'b0}};
        end else if (start_s) begin
            num_cnt_r  <= i_num_cnt;
            beats_in_r <= {CNT_BIT{1'b0}};
        end else if (beat_s) begin
            beats_in_r <= beats_in_r + CNT_BIT'(1);
        end else begin
            beats_in_r <= beats_in_r;
        end
    end

    // Quant stage: requantize and pack one accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_valid_r <= 1'b0;
            q_word0_r <= {DWIDTH{1'b0}};
            q_word1_r <= {DWIDTH{1'b0}};
        end else if (beat_s) begin
            q_valid_r <= 1'b1;
            q_word0_r <= {quant8(i_result_0), quant8(i_result_1),
                          quant8(i_result_2), quant8(i_result_3)};
            q_word1_r <= {quant8(i_result_4), quant8(i_result_5),
                          quant8(i_result_6), quant8(i_result_7)};
        end else begin
            q_valid_r <= 1'b0;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {q_word0_r, q_word1_r};
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {OCC_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + OCC_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - OCC_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Drain engine: word0 then word1 of the head entry on consecutive cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r   <= 1'b0;
            wr_addr_r <= {AWIDTH{1'b0}};
            addr_o    <= {AWIDTH{1'b0}};
            ce_o      <= 1'b0;
            we_o      <= 1'b0;
            d_o       <= {DWIDTH{1'b0}};
        end else if (start_s) begin
            phase_r   <= 1'b0;
            wr_addr_r <= {AWIDTH{1'b0}};
            ce_o      <= 1'b0;
            we_o      <= 1'b0;
        end else if (phase_r) begin
            phase_r   <= 1'b0;
            addr_o    <= wr_addr_r;
            d_o       <= head_s[DWIDTH-1:0];
            ce_o      <= 1'b1;
            we_o      <= 1'b1;
            wr_addr_r <= wr_addr_r + AWIDTH'(1);
        end else if (!fifo_empty_s) begin
            phase_r   <= 1'b1;
            addr_o    <= wr_addr_r;
            d_o       <= head_s[2*DWIDTH-1:DWIDTH];
            ce_o      <= 1'b1;
            we_o      <= 1'b1;
            wr_addr_r <= wr_addr_r + AWIDTH'(1);
        end else begin
            ce_o <= 1'b0;
            we_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fc_result_writer.sv
// Scoreboard bench for fc_result_writer: stimulus pushes expected BRAM words,
// a negedge monitor pops and compares every write and the done pulse.
module tb_fc_result_writer;

    localparam int CNT_BIT    = 31;
    localparam int DWIDTH     = 32;
    localparam int AWIDTH     = 12;
    localparam int SHIFT      = 8;
    localparam int FIFO_DEPTH = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               i_run = 1'b0;
    logic [CNT_BIT-1:0] i_num_cnt = '0;
    logic               i_valid = 1'b0;
    logic [DWIDTH-1:0]  res [8];
    logic               o_idle, o_busy, o_done, o_overflow, ce_o, we_o;
    logic [AWIDTH-1:0]  addr_o;
    logic [DWIDTH-1:0]  d_o;

    int          errors = 0;
    int          checks = 0;
    longint      cyc = 0;
    logic [31:0] exp_q [$];
    int          exp_addr = 0;
    int          run_writes = 0;
    longint      last_we_cyc = 0;
    int          done_cnt = 0;
    bit          lossy = 1'b0;
    int          k;

`ifdef RELU_EN
    localparam logic [7:0] NEG_C = 8'h00;
`else
    localparam logic [7:0] NEG_C = 8'h80;
`endif

    fc_result_writer #(
        .CNT_BIT(CNT_BIT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
        .SHIFT(SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_valid(i_valid),
        .i_result_0(res[0]), .i_result_1(res[1]), .i_result_2(res[2]), .i_result_3(res[3]),
        .i_result_4(res[4]), .i_result_5(res[5]), .i_result_6(res[6]), .i_result_7(res[7]),
        .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow),
        .addr_o(addr_o), .ce_o(ce_o), .we_o(we_o), .d_o(d_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Reference quantizer: floor division by 2^SHIFT, then clamp.
    function automatic logic [7:0] ref_q(input logic [31:0] x);
        longint v, y, dv;
        v  = longint'($signed(x));
        dv = longint'(1) << SHIFT;
`ifdef RELU_EN
        if (v < 0) v = 0;
`endif
        if (v >= 0) y = v / dv;
        else        y = -((-v + dv - 1) / dv);
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y[7:0];
    endfunction

    function automatic void push_model();
        exp_q.push_back({ref_q(res[0]), ref_q(res[1]), ref_q(res[2]), ref_q(res[3])});
        exp_q.push_back({ref_q(res[4]), ref_q(res[5]), ref_q(res[6]), ref_q(res[7])});
    endfunction

    // Monitor: every BRAM write and done pulse is checked against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (we_o) begin
                chk("ce_with_we", {63'd0, ce_o}, 64'd1);
                chk("addr", {52'd0, addr_o}, 64'(exp_addr % (1 << AWIDTH)));
                exp_addr++;
                run_writes++;
                last_we_cyc = cyc;
                if (lossy && !addr_o[0]) begin
                    while (exp_q.size() >= 2 && exp_q[0] !== d_o) begin
                        void'(exp_q.pop_front());
                        void'(exp_q.pop_front());
                    end
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h at addr %0d, nothing expected", d_o, addr_o);
                end else begin
                    chk("data", {32'd0, d_o}, {32'd0, exp_q.pop_front()});
                end
            end else begin
                chk("ce_idle", {63'd0, ce_o}, 64'd0);
            end
            if (o_done) begin
                done_cnt++;
                if (run_writes > 0) chk("done_latency", cyc, last_we_cyc + 1);
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_idle", {63'd0, o_idle}, 64'd1);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_done", {63'd0, o_done}, 64'd0);
        chk("rst_ovf", {63'd0, o_overflow}, 64'd0);
        chk("rst_ce_we", {62'd0, ce_o, we_o}, 64'd0);
        chk("rst_addr", {52'd0, addr_o}, 64'd0);
        chk("rst_d", {32'd0, d_o}, 64'd0);
    endtask

    task automatic start_run(input int n);
        @(posedge clk); #1;
        i_run = 1'b1;
        i_num_cnt = CNT_BIT'(n);
        run_writes = 0;
        exp_addr = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        i_run = 1'b0;
    endtask

    // One beat held for a cycle; the next call keeps i_valid high back-to-back.
    task automatic beat(input bit use_model);
        i_valid = 1'b1;
        if (use_model) push_model();
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic rand_res();
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0: res[i] = $urandom;
                1: res[i] = $urandom_range(0, 1) ? 32'($urandom_range(0, 65535))
                                                 : -32'($urandom_range(0, 65535));
                2: res[i] = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
                default: res[i] = $urandom >> $urandom_range(0, 31);
            endcase
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done_cnt == 0 && cycles < budget) begin
            @(posedge clk);
            cycles++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no o_done within %0d cycles", budget);
        end
        #1;
        chk("idle_after_done", {63'd0, o_idle}, 64'd1);
        chk("done_one_cycle", {63'd0, o_done}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) res[i] = '0;
        #12;
        chk_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;

        // i_valid while idle is ignored: no writes may follow.
        rand_res();
        beat(1'b0);
        beat(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_ignore_valid", {63'd0, o_idle}, 64'd1);

        // Basic single beat with known values.
        start_run(1);
        chk("busy_in_run", {62'd0, o_busy, o_idle}, 64'd2);
        for (int i = 0; i < 8; i++) res[i] = 32'((i + 1) * 256);
        exp_q.push_back(32'h0102_0304);
        exp_q.push_back(32'h0506_0708);
        beat(1'b0);
        wait_done(50, k);
        chk("t1_writes", 64'(run_writes), 64'd2);
        chk("t1_drained", 64'(exp_q.size()), 64'd0);

        // Saturation corners.
        start_run(1);
        res[0] = 32'h7FFF_FFFF; res[1] = 32'hFFFF_0000; res[2] = 32'h8000_0000; res[3] = 32'h0000_7F80;
        res[4] = 32'hFFFF_8000; res[5] = 32'hFFFF_7FFF; res[6] = 32'h0000_7FFF; res[7] = 32'h0000_8000;
        exp_q.push_back({8'h7F, NEG_C, NEG_C, 8'h7F});
        exp_q.push_back({NEG_C, NEG_C, 8'h7F, 8'h7F});
        beat(1'b0);
        wait_done(50, k);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);

        // Ten back-to-back beats fit without overflow.
        start_run(10);
        for (int b = 0; b < 10; b++) begin
            rand_res();
            beat(1'b1);
        end
        wait_done(200, k);
        chk("t3_overflow", {63'd0, o_overflow}, 64'd0);
        chk("t3_writes", 64'(run_writes), 64'd20);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);

        // Forty back-to-back beats overflow; run still completes.
        lossy = 1'b1;
        start_run(40);
        for (int b = 0; b < 40; b++) begin
            rand_res();
            beat(1'b1);
        end
        wait_done(400, k);
        chk("t4_overflow", {63'd0, o_overflow}, 64'd1);
        chk("t4_fewer_writes", {63'd0, (run_writes < 80)}, 64'd1);
        chk("t4_even_writes", 64'(run_writes % 2), 64'd0);
        chk("t4_some_writes", {63'd0, (run_writes >= 2 * FIFO_DEPTH)}, 64'd1);
        lossy = 1'b0;
        exp_q.delete();
        start_run(1);
        chk("t4_ovf_cleared", {63'd0, o_overflow}, 64'd0);
        rand_res();
        beat(1'b1);
        wait_done(50, k);
        chk("t4_next_drained", 64'(exp_q.size()), 64'd0);

        // Zero-length run: one RUN cycle, then done, no writes.
        start_run(0);
        chk("t5_busy", {63'd0, o_busy}, 64'd1);
        wait_done(10, k);
        chk("t5_run_cycles", 64'(k), 64'd2);
        chk("t5_no_writes", 64'(run_writes), 64'd0);

        // Reset mid-run, then a clean two-beat run.
        start_run(6);
        for (int b = 0; b < 3; b++) begin
            rand_res();
            beat(1'b1);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        start_run(2);
        for (int b = 0; b < 2; b++) begin
            rand_res();
            beat(1'b1);
        end
        wait_done(50, k);
        chk("t6_writes", 64'(run_writes), 64'd4);
        chk("t6_drained", 64'(exp_q.size()), 64'd0);

        // Random runs with gaps and surplus beats beyond num_cnt.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 12);
            start_run(n);
            for (int b = 0; b < n; b++) begin
                rand_res();
                beat(1'b1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            repeat ($urandom_range(0, 2)) begin
                rand_res();
                beat(1'b0);
            end
            wait_done(200, k);
            chk("rand_writes", 64'(run_writes), 64'(2 * n));
            chk("rand_drained", 64'(exp_q.size()), 64'd0);
            chk("rand_overflow", {63'd0, o_overflow}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
